sphere_seq_ctrl: RTL and testbench

Sequencer and output buffer for the 32-bit sphere point generator.
- Upstream side: takes a batch command (first k, point count, base selects). Issues one k at a time to the generator using its start/ready/done handshake.
- Downstream side: captures each (x, y, z) result with its k and pushes it into a small FIFO. The consumer drains the FIFO with valid/ready.
- Turns the one-shot generator into a back-pressured point stream for downstream consumers.

---
 rtl/sphere_pkg.sv | 45 ++++
 rtl/sphere_seq_ctrl_if.sv | 70 +++++++
 rtl/sphere_pt_fifo.sv | 71 +++++++
 rtl/sphere_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sphere_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sphere_pkg.sv
// sphere_pkg: shared definitions for the sphere point generator slice.
//   - sequencer state encoding (also exported on the debug port)
//   - 16.16 fixed-point constant FP_ONE and the coordinate width
//   - generator base-select codes and a helper that maps a code to its base
//   - the FIFO entry layout {x, y, z, k, last} (129 bits)
package sphere_pkg;

  localparam int COORD_W = 32;

  // 1.0 in 16.16 fixed point.
  localparam logic [COORD_W-1:0] FP_ONE = 32'h0001_0000;

  // Base-select codes understood by the generator.
  localparam logic [1:0] BASE_SEL_2 = 2'b00;
  localparam logic [1:0] BASE_SEL_3 = 2'b01;
  localparam logic [1:0] BASE_SEL_7 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE       = 2'd1,
    ST_WAIT_DONE   = 2'd2,
    ST_DRAIN_ABORT = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] k;
    logic               last;
  } pt_entry_t;

  localparam int PT_ENTRY_W = $bits(pt_entry_t);

  // Numeric base selected by a base-select code; the unused code 11
  // falls back to base 2.
  function automatic int unsigned base_of_sel(input logic [1:0] sel);
    case (sel)
      BASE_SEL_3: base_of_sel = 3;
      BASE_SEL_7: base_of_sel = 7;
      default:    base_of_sel = 2;
    endcase
  endfunction

endpackage

// File: rtl/sphere_seq_ctrl_if.sv
// sphere_seq_ctrl_if: bundle of all handshake/bus signals of sphere_seq_ctrl.
//   cmd_*   batch command channel (valid/ready)
//   abort, busy, batch_done  batch control/status
//   gen_*   generator start/ready/done channel
//   out_*   point stream (valid/ready)
// Modports: master = the sequencer, slave = its environment
// (command source, generator and point consumer).
//
// Handshake rule for cmd_* and out_*: a transfer happens on a rising clk
// edge where valid && ready are both high. Once valid is raised the sender
// holds valid and its payload stable until the transfer happens; ready may
// change freely and never depends on a transfer completing.
interface sphere_seq_ctrl_if
  import sphere_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_k_first;
  logic [CNT_W-1:0]   cmd_count;
  logic [1:0]         cmd_base_sel0;
  logic [1:0]         cmd_base_sel1;

  logic               abort;
  logic               busy;
  logic               batch_done;

  logic               gen_start;
  logic [COORD_W-1:0] gen_k;
  logic [1:0]         gen_base_sel0;
  logic [1:0]         gen_base_sel1;
  logic               gen_ready;
  logic               gen_done;
  logic [COORD_W-1:0] gen_x;
  logic [COORD_W-1:0] gen_y;
  logic [COORD_W-1:0] gen_z;

  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [COORD_W-1:0] out_z;
  logic [COORD_W-1:0] out_k;
  logic               out_last;

  modport master (
    input  cmd_valid, cmd_k_first, cmd_count, cmd_base_sel0, cmd_base_sel1,
    output cmd_ready,
    input  abort,
    output busy, batch_done,
    output gen_start, gen_k, gen_base_sel0, gen_base_sel1,
    input  gen_ready, gen_done, gen_x, gen_y, gen_z,
    output out_valid, out_x, out_y, out_z, out_k, out_last,
    input  out_ready
  );

  modport slave (
    output cmd_valid, cmd_k_first, cmd_count, cmd_base_sel0, cmd_base_sel1,
    input  cmd_ready,
    output abort,
    input  busy, batch_done,
    input  gen_start, gen_k, gen_base_sel0, gen_base_sel1,
    output gen_ready, gen_done, gen_x, gen_y, gen_z,
    input  out_valid, out_x, out_y, out_z, out_k, out_last,
    output out_ready
  );

endinterface

// File: rtl/sphere_pt_fifo.sv
// sphere_pt_fifo: first-word-fall-through FIFO of sphere point entries.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous clear of all entries (wins over push/pop)
//   push        write push_data (accepted when not full, or when popping)
//   push_data   entry {x, y, z, k, last}
//   pop         remove the head entry (ignored when empty)
//   head        current head entry; all zeros while empty
//   head_valid  FIFO not empty
//   occupancy   number of stored entries, 0..DEPTH
module sphere_pt_fifo
  import sphere_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  pt_entry_t push_data,
  input  logic      pop,
  output pt_entry_t head,
  output logic      head_valid,
  output logic [AW:0] occupancy
);

  localparam logic [AW:0] DEPTH_OCC = (AW + 1)'(DEPTH);

  pt_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  // A push at full is still taken when the head leaves in the same cycle,
  // which keeps occupancy unchanged and order intact.
  assign do_pop  = pop && (occ != '0);
  assign do_push = push && ((occ != DEPTH_OCC) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW + 1)'(1);
        2'b01:   occ <= occ - (AW + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (occ != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;
  assign occupancy  = occ;

endmodule

// File: rtl/sphere_seq_ctrl.sv
// sphere_seq_ctrl: sequencer and output buffer for the sphere point generator.
// Accepts a batch command, issues one k at a time to the generator, captures
// each (x, y, z) result with its k into a FWFT FIFO and streams it out with
// valid/ready back-pressure.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sphere_seq_ctrl_if.master: cmd_*, abort/busy/batch_done,
//               gen_* and out_* channels
//   dbg_state   current sequencer state
module sphere_seq_ctrl
  import sphere_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sphere_seq_ctrl_if.master         bus,
  output seq_state_t                dbg_state
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] FIFO_FULL_OCC = (FIFO_AW + 1)'(FIFO_DEPTH);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [COORD_W-1:0] k_cur_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [1:0]         sel0_q;
  logic [1:0]         sel1_q;
  logic               batch_done_q;

  logic               batch_done_d;
  logic               accept;
  logic               advance;
  logic               gen_start;
  logic               fifo_push;
  logic               fifo_flush;
  logic               fifo_room;
  logic               is_last;
  pt_entry_t          push_entry;
  pt_entry_t          head;
  logic               head_valid;
  logic [FIFO_AW:0]   fifo_occ;

  // Only one start is ever outstanding and it is issued only with a free
  // slot, so that slot is effectively reserved for its result.
  assign fifo_room = (fifo_occ < FIFO_FULL_OCC);
  assign is_last   = (remaining_q == CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    batch_done_d = 1'b0;
    accept       = 1'b0;
    advance      = 1'b0;
    gen_start    = 1'b0;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (bus.cmd_count == '0) batch_done_d = 1'b1;
          else                     state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Abort wins over firing: nothing is outstanding here.
        if (bus.abort) begin
          fifo_flush   = 1'b1;
          batch_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (bus.gen_ready && fifo_room) begin
          gen_start = 1'b1;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.abort) begin
          fifo_flush = 1'b1;
          // A done in the abort cycle closes the outstanding start; its
          // result is dropped.
          if (bus.gen_done) begin
            batch_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_DRAIN_ABORT;
          end
        end else if (bus.gen_done) begin
          fifo_push = 1'b1;
          advance   = 1'b1;
          if (is_last) begin
            batch_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DRAIN_ABORT: begin
        if (bus.gen_done) begin
          batch_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_cur_q      <= '0;
      remaining_q  <= '0;
      sel0_q       <= '0;
      sel1_q       <= '0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      batch_done_q <= batch_done_d;
      if (accept) begin
        k_cur_q     <= bus.cmd_k_first;
        remaining_q <= bus.cmd_count;
        sel0_q      <= bus.cmd_base_sel0;
        sel1_q      <= bus.cmd_base_sel1;
      end else if (advance) begin
        // k wraps naturally modulo 2^32.
        k_cur_q     <= k_cur_q + COORD_W'(1);
        remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

  assign push_entry = '{x: bus.gen_x, y: bus.gen_y, z: bus.gen_z,
                        k: k_cur_q, last: is_last};

  sphere_pt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (bus.out_ready),
    .head       (head),
    .head_valid (head_valid),
    .occupancy  (fifo_occ)
  );

  assign bus.cmd_ready     = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.batch_done    = batch_done_q;
  assign bus.gen_start     = gen_start;
  assign bus.gen_k         = k_cur_q;
  assign bus.gen_base_sel0 = sel0_q;
  assign bus.gen_base_sel1 = sel1_q;
  assign bus.out_valid     = head_valid;
  assign bus.out_x         = head.x;
  assign bus.out_y         = head.y;
  assign bus.out_z         = head.z;
  assign bus.out_k         = head.k;
  assign bus.out_last      = head.last;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_sphere_seq_ctrl.sv
// tb_sphere_seq_ctrl: self-checking bench for sphere_seq_ctrl with a stub
// generator (fixed latency, x=k, y=~k, z=k<<16) and a queue-based model of
// the expected point stream.
module tb_sphere_seq_ctrl;
  import sphere_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int GEN_LAT    = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  seq_state_t dbg_state;

  always #5 clk = ~clk;

  sphere_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  sphere_seq_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- stub generator ----------------
  int          g_cnt;
  int          g_cool;
  logic [31:0] g_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_cnt         <= 0;
      g_cool        <= 0;
      g_k           <= '0;
      bus.gen_ready <= 1'b1;
      bus.gen_done  <= 1'b0;
      bus.gen_x     <= '0;
      bus.gen_y     <= '0;
      bus.gen_z     <= '0;
    end else begin
      bus.gen_done <= 1'b0;
      if (bus.gen_start && bus.gen_ready) begin
        g_cnt         <= GEN_LAT;
        g_k           <= bus.gen_k;
        bus.gen_ready <= 1'b0;
      end else if (g_cnt > 1) begin
        g_cnt <= g_cnt - 1;
      end else if (g_cnt == 1) begin
        g_cnt        <= 0;
        g_cool       <= 2;
        bus.gen_done <= 1'b1;
        bus.gen_x    <= g_k;
        bus.gen_y    <= ~g_k;
        bus.gen_z    <= g_k << 16;
      end else if (g_cool > 0) begin
        g_cool <= g_cool - 1;
        if (g_cool == 1) bus.gen_ready <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [128:0] exp_q[$];
  logic [1:0]   exp_sel0;
  logic [1:0]   exp_sel1;
  int           start_cnt = 0;
  int           done_cnt = 0;
  logic [128:0] held;
  logic         held_v = 1'b0;
  logic         rnd_ready = 1'b0;

  always @(negedge clk) begin
    logic [128:0] head;
    logic [128:0] e;
    head = {bus.out_x, bus.out_y, bus.out_z, bus.out_k, bus.out_last};
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (bus.gen_start) begin
        start_cnt++;
        check("start_needs_ready", 129'(bus.gen_ready), 129'(1'b1));
        check("gen_base_sel0", 129'(bus.gen_base_sel0), 129'(exp_sel0));
        check("gen_base_sel1", 129'(bus.gen_base_sel1), 129'(exp_sel1));
      end
      if (bus.batch_done) done_cnt++;
      if (bus.gen_done) check("gen_k_stable", 129'(bus.gen_k), 129'(g_k));
      if (held_v && bus.out_valid) check("out_hold_stable", head, held);
      held_v = bus.out_valid && !bus.out_ready;
      held   = head;
      if (bus.out_valid && bus.out_ready) begin
        check("sb_has_expected", 129'(exp_q.size() != 0), 129'(1'b1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_entry", head, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_batch(input logic [31:0] k, input int cnt);
    logic [31:0] kk;
    for (int i = 0; i < cnt; i++) begin
      kk = k + 32'(i);
      exp_q.push_back({kk, ~kk, kk << 16, kk, (i == cnt - 1)});
    end
  endtask

  task automatic send_cmd(input logic [31:0] k, input int cnt, input logic [1:0] s0, input logic [1:0] s1);
    int g;
    bus.cmd_valid     = 1'b1;
    bus.cmd_k_first   = k;
    bus.cmd_count     = CNT_W'(cnt);
    bus.cmd_base_sel0 = s0;
    bus.cmd_base_sel1 = s1;
    g = 0;
    while (!bus.cmd_ready && g < 100) begin
      cyc(1);
      g++;
    end
    check("cmd_ready_for_accept", 129'(bus.cmd_ready), 129'(1'b1));
    exp_sel0 = s0;
    exp_sel1 = s1;
    model_batch(k, cnt);
    cyc(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int g;
    g = 0;
    while (done_cnt == d0 && g < budget) begin
      cyc(1);
      g++;
    end
    check("batch_done_seen", 129'(done_cnt != d0), 129'(1'b1));
  endtask

  task automatic wait_drain(input int budget);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      cyc(1);
      g++;
    end
    check("fifo_drained", 129'(exp_q.size()), 129'(0));
  endtask

  task automatic run_batch(input logic [31:0] k, input int cnt, input logic [1:0] s0, input logic [1:0] s1);
    int d0;
    int st;
    d0 = done_cnt;
    st = start_cnt;
    send_cmd(k, cnt, s0, s1);
    wait_done(d0, 800);
    cyc(3);
    check("batch_done_pulses", 129'(done_cnt - d0), 129'(1));
    check("start_pulses", 129'(start_cnt - st), 129'(cnt));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int st;
    int g;
    bus.cmd_valid     = 1'b0;
    bus.cmd_k_first   = '0;
    bus.cmd_count     = '0;
    bus.cmd_base_sel0 = '0;
    bus.cmd_base_sel1 = '0;
    bus.abort         = 1'b0;
    bus.out_ready     = 1'b1;
    exp_sel0          = '0;
    exp_sel1          = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 129'(bus.cmd_ready), 129'(1'b1));
    check("rst_busy", 129'(bus.busy), 129'(1'b0));
    check("rst_batch_done", 129'(bus.batch_done), 129'(1'b0));
    check("rst_gen_start", 129'(bus.gen_start), 129'(1'b0));
    check("rst_gen_k_sel", 129'({bus.gen_k, bus.gen_base_sel0, bus.gen_base_sel1}), 129'(0));
    check("rst_out_valid", 129'(bus.out_valid), 129'(1'b0));
    check("rst_out_data", {bus.out_x, bus.out_y, bus.out_z, bus.out_k, bus.out_last}, 129'(0));
    rst_n = 1'b1;
    cyc(2);

    // Basic batch: k=1..3, last only on k=3.
    run_batch(32'd1, 3, 2'b00, 2'b01);
    wait_drain(50);

    // Zero-count batch.
    d0 = done_cnt;
    st = start_cnt;
    send_cmd(32'd77, 0, 2'b01, 2'b10);
    check("zero_cnt_done_pulse", 129'(bus.batch_done), 129'(1'b1));
    cyc(1);
    check("zero_cnt_done_one_cycle", 129'(bus.batch_done), 129'(1'b0));
    cyc(10);
    check("zero_cnt_no_start", 129'(start_cnt - st), 129'(0));
    check("zero_cnt_one_done", 129'(done_cnt - d0), 129'(1));
    check("zero_cnt_no_out", 129'(bus.out_valid), 129'(1'b0));

    // Back-pressure: FIFO fills, issuing stalls at FIFO_DEPTH starts.
    bus.out_ready = 1'b0;
    d0 = done_cnt;
    st = start_cnt;
    send_cmd(32'h1000, 6, 2'b10, 2'b00);
    cyc(80);
    check("bp_starts_capped", 129'(start_cnt - st), 129'(FIFO_DEPTH));
    check("bp_out_valid", 129'(bus.out_valid), 129'(1'b1));
    check("bp_still_busy", 129'(bus.busy), 129'(1'b1));
    check("bp_waiting_to_issue", 129'(dbg_state), 129'(ST_ISSUE));
    bus.out_ready = 1'b1;
    wait_done(d0, 400);
    cyc(3);
    check("bp_total_starts", 129'(start_cnt - st), 129'(6));
    wait_drain(50);

    // k wraps modulo 2^32.
    run_batch(32'hFFFF_FFFE, 3, 2'b01, 2'b01);
    wait_drain(50);

    // Abort two cycles after the second start, one entry buffered.
    bus.out_ready = 1'b0;
    d0 = done_cnt;
    st = start_cnt;
    send_cmd(32'd100, 5, 2'b00, 2'b10);
    g = 0;
    while (start_cnt - st < 2 && g < 200) begin
      cyc(1);
      g++;
    end
    check("abort_second_start_seen", 129'(start_cnt - st), 129'(2));
    cyc(1);
    check("abort_one_entry_buffered", 129'(bus.out_valid), 129'(1'b1));
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    exp_q.delete();
    check("abort_fifo_flushed", 129'(bus.out_valid), 129'(1'b0));
    check("abort_drain_state", 129'(dbg_state), 129'(ST_DRAIN_ABORT));
    wait_done(d0, 50);
    cyc(8);
    check("abort_cmd_ready", 129'(bus.cmd_ready), 129'(1'b1));
    check("abort_result_discarded", 129'(bus.out_valid), 129'(1'b0));
    check("abort_no_more_starts", 129'(start_cnt - st), 129'(2));
    check("abort_one_done", 129'(done_cnt - d0), 129'(1));
    bus.out_ready = 1'b1;

    // Randomized batches with random consumer back-pressure.
    rnd_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      run_batch($urandom(), $urandom_range(1, 6),
                2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
      wait_drain(300);
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    cyc(2);

    // Reset during WAIT_DONE.
    st = start_cnt;
    send_cmd(32'd500, 4, 2'b01, 2'b00);
    g = 0;
    while (start_cnt == st && g < 100) begin
      cyc(1);
      g++;
    end
    cyc(2);
    check("mid_rst_in_wait", 129'(dbg_state), 129'(ST_WAIT_DONE));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_cmd_ready", 129'(bus.cmd_ready), 129'(1'b1));
    check("mid_rst_busy", 129'(bus.busy), 129'(1'b0));
    check("mid_rst_gen", 129'({bus.gen_start, bus.gen_k, bus.gen_base_sel0, bus.gen_base_sel1}), 129'(0));
    check("mid_rst_out", {bus.out_x, bus.out_y, bus.out_z, bus.out_k, bus.out_last}, 129'(0));
    check("mid_rst_out_valid_done", 129'({bus.out_valid, bus.batch_done}), 129'(0));
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    run_batch(32'd900, 2, 2'b10, 2'b01);
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
